// File: rtl/warp_end_collector_pkg.sv
// Shared warp-slot sizing for the warp-end collector and its arbiter.
package warp_end_collector_pkg;
  localparam int WEC_NUM_WARP   = 8;
  localparam int WEC_DEPTH_WARP = 3;
endpackage

// File: rtl/warp_end_collector_rr_arb.sv
// Round-robin arbiter: one-hot grant of the first request at or above ptr, wrapping.
import warp_end_collector_pkg::*;

module rr_arb #(
  parameter int ARB_WIDTH = WEC_NUM_WARP,
  parameter int PTR_W     = $clog2(ARB_WIDTH)
) (
  input  logic [ARB_WIDTH-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [ARB_WIDTH-1:0] grant
);
  logic [ARB_WIDTH-1:0]   hi_mask;
  logic [2*ARB_WIDTH-1:0] dbl;
  logic [2*ARB_WIDTH-1:0] gdbl;
  logic                   found;

  // Lower copy keeps only requests at/above ptr; upper copy supplies the wrap.
  assign hi_mask = {ARB_WIDTH{1'b1}} << ptr;
  assign dbl     = {req, req & hi_mask};

  always_comb begin
    gdbl  = '0;
    found = 1'b0;
    for (int i = 0; i < 2*ARB_WIDTH; i++) begin
      if (!found && dbl[i]) begin
        gdbl[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign grant = gdbl[ARB_WIDTH-1:0] | gdbl[2*ARB_WIDTH-1:ARB_WIDTH];
endmodule

// File: rtl/warp_end_collector.sv
// Latches per-warp end pulses in a pending bitmap and drains them one id per handshake, round-robin.
import warp_end_collector_pkg::*;

module warp_end_collector #(
  parameter int NUM_WARP   = WEC_NUM_WARP,
  parameter int DEPTH_WARP = WEC_DEPTH_WARP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WARP-1:0]   warp_end_i,
  input  logic                  warpRsp_ready_i,
  output logic                  warpRsp_valid_o,
  output logic [DEPTH_WARP-1:0] warpRsp_wid_o,
  output logic [DEPTH_WARP:0]   pending_cnt_o,
  output logic                  dup_err_o
);
  logic [NUM_WARP-1:0]   pending;
  logic [DEPTH_WARP-1:0] rr_ptr;
  logic                  dup_err;
  logic [NUM_WARP-1:0]   grant;
  logic [NUM_WARP-1:0]   clear_mask;
  logic                  fire;

  function automatic logic [DEPTH_WARP-1:0] one2bin(input logic [NUM_WARP-1:0] oh);
    logic [DEPTH_WARP-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_WARP; i++)
      if (oh[i]) b = b | DEPTH_WARP'(i);
    return b;
  endfunction

  function automatic logic [DEPTH_WARP:0] popcnt(input logic [NUM_WARP-1:0] v);
    logic [DEPTH_WARP:0] c;
    c = '0;
    for (int i = 0; i < NUM_WARP; i++)
      c = c + (DEPTH_WARP+1)'(v[i]);
    return c;
  endfunction

  rr_arb #(.ARB_WIDTH(NUM_WARP), .PTR_W(DEPTH_WARP)) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Outputs depend on registered state only; nothing combinational from warp_end_i.
  assign warpRsp_valid_o = |pending;
  assign warpRsp_wid_o   = one2bin(grant);
  assign pending_cnt_o   = popcnt(pending);
  assign dup_err_o       = dup_err;

  assign fire       = warpRsp_valid_o && warpRsp_ready_i;
  assign clear_mask = fire ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      rr_ptr  <= '0;
      dup_err <= 1'b0;
    end else begin
      // Set wins over clear: a warp draining this cycle may legitimately end again.
      pending <= (pending & ~clear_mask) | warp_end_i;
      if (|(warp_end_i & pending & ~clear_mask))
        dup_err <= 1'b1;
      if (fire)
        rr_ptr <= (warpRsp_wid_o == DEPTH_WARP'(NUM_WARP-1)) ? '0
                                                               : warpRsp_wid_o + DEPTH_WARP'(1);
    end
  end
endmodule

// File: tb/tb_warp_end_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-free bitmap model.
module tb_warp_end_collector;
  localparam int NW = 8;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] warp_end_i = '0;
  logic          ready = 1'b0;
  logic          valid;
  logic [DW-1:0] wid;
  logic [DW:0]   cnt;
  logic          dup;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit m_pend [NW];
  int m_rr;
  bit m_dup;

  always #5 clk = ~clk;

  warp_end_collector #(.NUM_WARP(NW), .DEPTH_WARP(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .warp_end_i      (warp_end_i),
    .warpRsp_ready_i (ready),
    .warpRsp_valid_o (valid),
    .warpRsp_wid_o   (wid),
    .pending_cnt_o   (cnt),
    .dup_err_o       (dup)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < NW; k++)
      if (m_pend[(m_rr + k) % NW]) return (m_rr + k) % NW;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NW; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NW; i++) m_pend[i] = 1'b0;
    m_rr  = 0;
    m_dup = 1'b0;
  endtask

  // Compare DUT against model for the current state.
  task automatic check_model();
    int w;
    w = m_winner();
    chk("valid", int'(valid), int'(w >= 0));
    chk("wid",   int'(wid),   (w >= 0) ? w : 0);
    chk("cnt",   int'(cnt),   m_count());
    chk("dup",   int'(dup),   int'(m_dup));
  endtask

  // One cycle: called at a negedge; checks, drives, advances model, waits next negedge.
  task automatic cyc(input logic [NW-1:0] we, input logic rdy);
    int w;
    check_model();
    warp_end_i = we;
    ready      = rdy;
    w = m_winner();
    for (int i = 0; i < NW; i++) begin
      bit clr;
      clr = rdy && (w == i);
      if (we[i] && m_pend[i] && !clr) m_dup = 1'b1;
      m_pend[i] = (m_pend[i] && !clr) || we[i];
    end
    if (rdy && w >= 0) m_rr = (w + 1) % NW;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    warp_end_i = '0;
    ready = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_wid",   int'(wid),   0);
    chk("rst_cnt",   int'(cnt),   0);
    chk("rst_dup",   int'(dup),   0);
    rst = 1'b0;
    @(negedge clk);

    // single event
    cyc(8'h10, 1'b1);
    chk("single_valid", int'(valid), 1);
    chk("single_wid",   int'(wid),   4);
    chk("single_cnt",   int'(cnt),   1);
    cyc(8'h00, 1'b1);
    chk("single_empty", int'(valid), 0);
    cyc(8'h21, 1'b0);   // rr_ptr should now be 5, so 5 beats 0
    chk("single_rrptr", int'(wid), 5);
    cyc(8'h00, 1'b0);

    // simultaneous events, round-robin
    do_reset();
    cyc(8'h85, 1'b1);
    chk("rr_w0", int'(wid), 0);
    cyc(8'h00, 1'b1);
    chk("rr_w2", int'(wid), 2);
    cyc(8'h00, 1'b1);
    chk("rr_w7", int'(wid), 7);
    cyc(8'h00, 1'b1);
    chk("rr_empty", int'(valid), 0);

    // backpressure: build pending 03 with rr_ptr 1
    do_reset();
    cyc(8'h01, 1'b1);
    cyc(8'h03, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 1'b0);
      chk("bp_wid", int'(wid), 1);
      chk("bp_cnt", int'(cnt), 2);
    end
    cyc(8'h00, 1'b1);
    chk("bp_then0", int'(wid), 0);
    cyc(8'h00, 1'b1);
    chk("bp_empty", int'(valid), 0);

    // set/clear collision, then duplicate
    do_reset();
    cyc(8'h08, 1'b1);
    cyc(8'h08, 1'b1);
    chk("coll_valid", int'(valid), 1);
    chk("coll_wid",   int'(wid),   3);
    chk("coll_dup",   int'(dup),   0);
    cyc(8'h08, 1'b0);
    chk("dup_set", int'(dup), 1);
    chk("dup_cnt", int'(cnt), 1);
    cyc(8'h00, 1'b1);
    chk("dup_sticky", int'(dup), 1);

    // reset mid-drain
    do_reset();
    cyc(8'hFF, 1'b1);
    chk("full_cnt", int'(cnt), 8);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    chk("drain_cnt", int'(cnt), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_cnt",   int'(cnt),   0);
    m_reset();
    warp_end_i = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    chk("post_rst_valid", int'(valid), 0);

    // random traffic: sparse pulses, random ready, occasional bursts
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [NW-1:0] we;
      we = '0;
      if ($urandom_range(0, 9) < 3) we = NW'($urandom);
      if ($urandom_range(0, 99) == 0) we = '1;
      cyc(we, 1'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
